// File: rtl/spi_display_arbiter.sv
// Shares one SPI panel link between init, clear and draw clients:
// boots with init then clear, then serves queued clear/draw jobs with a per-job timeout.
module spi_display_arbiter #(
  parameter int TIMEOUT = 27_000_000,
  parameter int TW      = 25
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clear_req,
  input  logic       i_draw_req,
  output logic [2:0] o_start,
  input  logic [2:0] i_done,
  input  logic [2:0] i_mosi,
  input  logic [2:0] i_dc,
  input  logic [2:0] i_cs,
  output logic       o_mosi,
  output logic       o_dc,
  output logic       o_cs,
  output logic       o_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error
);

  typedef enum logic [2:0] {
    BOOT_INIT, WAIT_INIT, BOOT_CLEAR, WAIT_CLEAR, IDLE, START, BUSY, FAULT
  } state_t;

  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [2:0]    grant, sel;
  logic          pend_clear, pend_draw;
  logic [TW-1:0] cnt;
  logic          done_g, tmo, in_wait, take;

  // Only the granted client's done counts; everything else is noise.
  assign done_g  = |(i_done & grant);
  assign in_wait = (state == WAIT_INIT) || (state == WAIT_CLEAR) || (state == BUSY);
  assign tmo     = in_wait && (cnt == CNT_LAST) && !done_g;
  assign take    = (state == IDLE) && (state_nxt == START);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= BOOT_INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT_INIT:  state_nxt = WAIT_INIT;
      WAIT_INIT:  if (done_g) state_nxt = BOOT_CLEAR; else if (tmo) state_nxt = FAULT;
      BOOT_CLEAR: state_nxt = WAIT_CLEAR;
      WAIT_CLEAR: if (done_g) state_nxt = IDLE; else if (tmo) state_nxt = FAULT;
      IDLE:       if (pend_clear || pend_draw) state_nxt = START;
      START:      state_nxt = BUSY;
      BUSY:       if (done_g || tmo) state_nxt = IDLE;
      FAULT:      state_nxt = FAULT;
      default:    state_nxt = BOOT_INIT;
    endcase
  end

  // Grant and start are decoded from state; reset masks them so the link idles immediately.
  always_comb begin
    grant   = 3'b000;
    o_start = 3'b000;
    o_busy  = 1'b0;
    if (!i_rst) begin
      case (state)
        BOOT_INIT:  begin grant = 3'b001; o_start = 3'b001; end
        WAIT_INIT:  grant = 3'b001;
        BOOT_CLEAR: begin grant = 3'b010; o_start = 3'b010; end
        WAIT_CLEAR: grant = 3'b010;
        START:      begin grant = sel; o_start = sel; o_busy = 1'b1; end
        BUSY:       begin grant = sel; o_busy = 1'b1; end
        default:    grant = 3'b000;
      endcase
    end
  end

  always_comb begin
    o_mosi = 1'b0;
    o_dc   = 1'b0;
    o_cs   = 1'b1;
    case (grant)
      3'b001:  begin o_mosi = i_mosi[0]; o_dc = i_dc[0]; o_cs = i_cs[0]; end
      3'b010:  begin o_mosi = i_mosi[1]; o_dc = i_dc[1]; o_cs = i_cs[1]; end
      3'b100:  begin o_mosi = i_mosi[2]; o_dc = i_dc[2]; o_cs = i_cs[2]; end
      default: begin o_mosi = 1'b0; o_dc = 1'b0; o_cs = 1'b1; end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend_clear <= 1'b0;
      pend_draw  <= 1'b0;
      sel        <= 3'b000;
      cnt        <= '0;
      o_ready    <= 1'b0;
      o_done     <= 1'b0;
      o_error    <= 1'b0;
    end else begin
      cnt    <= in_wait ? cnt + TW'(1) : '0;
      o_done <= (state == BUSY) && done_g;
      if (tmo) o_error <= 1'b1;
      if ((state == WAIT_CLEAR) && done_g) o_ready <= 1'b1;
      if (take) sel <= pend_clear ? 3'b010 : 3'b100;
      // A new request in the cycle its bit is consumed keeps the bit set.
      if (state != FAULT) begin
        pend_clear <= i_clear_req | (pend_clear & ~take);
        pend_draw  <= i_draw_req  | (pend_draw  & ~(take & ~pend_clear));
      end
    end
  end

endmodule

// File: tb/tb_spi_display_arbiter.sv
// Directed bench for spi_display_arbiter: boot, priority table, spurious done,
// set-dominant pending, runtime/boot timeouts and mid-job reset.
module tb_spi_display_arbiter;

  logic       clk = 1'b0;
  logic       i_rst, i_clear_req, i_draw_req;
  logic [2:0] i_done, o_start;
  logic [2:0] i_mosi, i_dc, i_cs;
  logic       o_mosi, o_dc, o_cs, o_ready, o_busy, o_done, o_error;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  spi_display_arbiter #(.TIMEOUT(100), .TW(8)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_clear_req(i_clear_req), .i_draw_req(i_draw_req),
    .o_start(o_start), .i_done(i_done), .i_mosi(i_mosi), .i_dc(i_dc), .i_cs(i_cs),
    .o_mosi(o_mosi), .o_dc(o_dc), .o_cs(o_cs), .o_ready(o_ready), .o_busy(o_busy),
    .o_done(o_done), .o_error(o_error)
  );

  // Link signature {mosi,dc,cs}: init 110, clear 011, draw 100, no grant 001.
  localparam logic [2:0] M_INIT = 3'b110, M_CLR = 3'b011, M_DRW = 3'b100, M_NONE = 3'b001;

  typedef struct packed {
    logic       cr, dr;
    logic [2:0] dn, start;
    logic       busy, done;
    logic [2:0] mux;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs after the falling edge, outputs settle 1ns later.
  task automatic tick(input logic rst, input logic cr, input logic dr, input logic [2:0] dn);
    @(negedge clk);
    i_rst = rst; i_clear_req = cr; i_draw_req = dr; i_done = dn;
    #1;
  endtask

  function automatic logic [2:0] mux();
    return {o_mosi, o_dc, o_cs};
  endfunction

  initial begin
    i_mosi = 3'b101; i_dc = 3'b011; i_cs = 3'b010;
    i_rst = 1'b1; i_clear_req = 1'b0; i_draw_req = 1'b0; i_done = 3'b000;

    // Reset state
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    chk("rst_start", o_start, 3'b000);
    chk("rst_busy", o_busy, 0);
    chk("rst_ready", o_ready, 0);
    chk("rst_done", o_done, 0);
    chk("rst_error", o_error, 0);
    chk("rst_mux", mux(), M_NONE);

    // Boot: init done 10 cycles after start, clear done 20 cycles after start
    tick(0, 0, 0, 0);
    chk("boot_start_init", o_start, 3'b001);
    chk("boot_mux_init", mux(), M_INIT);
    for (int k = 1; k <= 10; k++) begin
      tick(0, 0, 0, (k == 10) ? 3'b001 : 3'b000);
      chk("wait_init_start", o_start, 3'b000);
      chk("wait_init_mux", mux(), M_INIT);
    end
    tick(0, 0, 0, 0);
    chk("boot_start_clear", o_start, 3'b010);
    chk("boot_mux_clear", mux(), M_CLR);
    chk("boot_ready_early", o_ready, 0);
    for (int k = 1; k <= 20; k++) begin
      tick(0, 0, 0, (k == 20) ? 3'b010 : 3'b000);
      chk("wait_clear_mux", mux(), M_CLR);
    end
    tick(0, 0, 0, 0);
    chk("boot_ready", o_ready, 1);
    chk("boot_idle_mux", mux(), M_NONE);
    chk("boot_no_done", o_done, 0);

    // Priority and spurious done, one row per cycle
    tbl[0]  = '{1'b1, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, M_NONE};
    tbl[1]  = '{1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, M_NONE};
    tbl[2]  = '{1'b0, 1'b0, 3'b000, 3'b010, 1'b1, 1'b0, M_CLR};
    tbl[3]  = '{1'b0, 1'b0, 3'b100, 3'b000, 1'b1, 1'b0, M_CLR};
    tbl[4]  = '{1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, M_CLR};
    tbl[5]  = '{1'b0, 1'b0, 3'b010, 3'b000, 1'b1, 1'b0, M_CLR};
    tbl[6]  = '{1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, M_NONE};
    tbl[7]  = '{1'b0, 1'b0, 3'b000, 3'b100, 1'b1, 1'b0, M_DRW};
    tbl[8]  = '{1'b0, 1'b0, 3'b001, 3'b000, 1'b1, 1'b0, M_DRW};
    tbl[9]  = '{1'b0, 1'b0, 3'b100, 3'b000, 1'b1, 1'b0, M_DRW};
    tbl[10] = '{1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, M_NONE};
    tbl[11] = '{1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, M_NONE};
    for (int i = 0; i < 12; i++) begin
      tick(0, tbl[i].cr, tbl[i].dr, tbl[i].dn);
      chk($sformatf("tbl%0d_start", i), o_start, tbl[i].start);
      chk($sformatf("tbl%0d_busy", i), o_busy, tbl[i].busy);
      chk($sformatf("tbl%0d_done", i), o_done, tbl[i].done);
      chk($sformatf("tbl%0d_mux", i), mux(), tbl[i].mux);
      chk($sformatf("tbl%0d_error", i), o_error, 0);
    end

    // Draw request in the cycle its pending bit is consumed stays pending
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    chk("sd_start1", o_start, 3'b100);
    tick(0, 0, 0, 3'b100);
    tick(0, 0, 0, 0);
    chk("sd_done1", o_done, 1);
    chk("sd_gap", o_start, 3'b000);
    tick(0, 0, 0, 0);
    chk("sd_start2", o_start, 3'b100);

    // Second draw job never finishes: runtime timeout after 100 BUSY cycles
    for (int k = 1; k <= 100; k++) begin
      tick(0, 0, 0, 0);
      chk("rt_busy", o_busy, 1);
      chk("rt_no_done", o_done, 0);
    end
    tick(0, 0, 0, 0);
    chk("rt_error", o_error, 1);
    chk("rt_idle", o_busy, 0);
    chk("rt_done_quiet", o_done, 0);
    chk("rt_mux", mux(), M_NONE);
    tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("rt_later_start", o_start, 3'b100);
    tick(0, 0, 0, 3'b100);
    tick(0, 0, 0, 0);
    chk("rt_later_done", o_done, 1);
    chk("rt_error_sticky", o_error, 1);

    // Reset in the middle of a BUSY draw job
    tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("mr_in_busy", o_busy, 1);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    chk("mr_busy", o_busy, 0);
    chk("mr_ready", o_ready, 0);
    chk("mr_error", o_error, 0);
    chk("mr_start", o_start, 3'b000);
    chk("mr_mux", mux(), M_NONE);
    tick(0, 0, 0, 0);
    chk("mr_boot_start", o_start, 3'b001);

    // Boot timeout: init done withheld, non-granted dones ignored, FAULT latches
    for (int k = 1; k <= 100; k++) begin
      tick(0, 0, 0, (k == 50) ? 3'b110 : 3'b000);
      chk("bt_mux", mux(), M_INIT);
      chk("bt_error", o_error, 0);
    end
    tick(0, 1, 1, 0);
    chk("bt_fault_error", o_error, 1);
    chk("bt_fault_ready", o_ready, 0);
    chk("bt_fault_mux", mux(), M_NONE);
    for (int k = 0; k < 4; k++) begin
      tick(0, 1, 1, 3'b111);
      chk("bt_fault_start", o_start, 3'b000);
      chk("bt_fault_busy", o_busy, 0);
    end
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    chk("bt_rst_error", o_error, 0);
    tick(0, 0, 0, 0);
    chk("bt_reboot_start", o_start, 3'b001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_display_arbiter.md
SPI_DISPLAY_ARBITER -- requirements
Module: spi_display_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 27_000_000, cycles allowed per job before abort.
REQ-002 Parameter TW, default 25, timeout counter width; SHALL hold TIMEOUT-1.
REQ-003 i_clk  input  1  system clock; all logic on rising edge.
REQ-004 i_rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-005 i_clear_req  input  1  one-cycle pulse, request full-screen clear.
REQ-006 i_draw_req  input  1  one-cycle pulse, request draw job.
REQ-007 o_start  output  3  one-hot start pulse; bit0 init, bit1 clear, bit2 draw.
REQ-008 i_done  input  3  one-hot done pulses from the init, clear and draw clients.
REQ-009 i_mosi, i_dc, i_cs  input  3 each  per-client SPI signals, same bit order as o_start.
REQ-010 o_mosi, o_dc, o_cs  output  1 each  shared SPI link to panel.
REQ-011 o_ready  output  1  boot sequence (init then clear) complete.
REQ-012 o_busy  output  1  a job is granted and running.
REQ-013 o_done  output  1  one-cycle pulse when a runtime job completes.
REQ-014 o_error  output  1  sticky: a job timed out.

Function
REQ-015 States: BOOT_INIT, WAIT_INIT, BOOT_CLEAR, WAIT_CLEAR, IDLE, START, BUSY, FAULT.
REQ-016 BOOT_INIT: o_start=3'b001, grant=init; next cycle WAIT_INIT.
REQ-017 WAIT_INIT: on i_done[0] -> BOOT_CLEAR.
REQ-018 BOOT_CLEAR: o_start=3'b010, grant=clear; next cycle WAIT_CLEAR.
REQ-019 WAIT_CLEAR: on i_done[1] -> IDLE, o_ready=1 from that transition onward.
REQ-020 Requests latch into pending bits pend_clear/pend_draw in every state, including during boot; the pending bit is cleared when its START is issued.
REQ-021 IDLE: if pend_clear -> START(clear); else if pend_draw -> START(draw); clear has priority over draw.
REQ-022 START: o_start one-hot for the selected client for exactly one cycle; grant set in the same cycle; next cycle BUSY.
REQ-023 BUSY: on i_done bit of the granted client -> o_done pulse one cycle, grant released, IDLE.
REQ-024 i_done bits of non-granted clients SHALL be ignored in all states.
REQ-025 o_busy=1 in START and BUSY, 0 otherwise.
REQ-026 Mux: o_mosi/o_dc/o_cs driven combinationally from the granted client's inputs; with no grant: o_cs=1, o_mosi=0, o_dc=0.
REQ-027 Grant is held constant from START (or BOOT_*) until the done or timeout cycle; no switch mid-job.
REQ-028 Timeout counter cleared on entry to WAIT_INIT, WAIT_CLEAR or BUSY; increments each cycle in those states.
REQ-029 Counter reaching TIMEOUT-1 without granted done: o_error<=1, grant released.
REQ-030 Timeout in WAIT_INIT/WAIT_CLEAR -> FAULT; FAULT ignores requests, o_ready=0, exited only by reset.
REQ-031 Timeout in BUSY -> IDLE, no o_done pulse; pending requests are still served.
REQ-032 Granted done and timeout in the same cycle: done wins, o_error unchanged.
REQ-033 A request arriving in the same cycle its pending bit is cleared SHALL remain pending (set dominates).
REQ-034 Back-to-back: after BUSY->IDLE, the next START occurs no earlier than one cycle later.

Reset
REQ-035 While i_rst=1 at a clock edge: state=BOOT_INIT, pending bits=0, counter=0, grant none, o_ready=0, o_busy=0, o_done=0, o_error=0, o_start=0.
REQ-036 Mid-job reset aborts the job; boot restarts with the o_start=3'b001 pulse in the first cycle after i_rst deasserts.

Verification (TIMEOUT=100)
REQ-037 Boot: release reset, return i_done[0] 10 cycles after the init start and i_done[1] 20 cycles after the clear start -> o_start 001 then 010, o_ready=1, o_cs follows init then clear.
REQ-038 Priority: with o_ready=1, pulse i_clear_req and i_draw_req in the same cycle -> clear job first, then draw; two o_done pulses.
REQ-039 Spurious done: pulse i_done[2] while clear is granted -> ignored, grant stays clear.
REQ-040 Runtime timeout: draw granted, no done for 100 cycles -> o_error=1, IDLE, o_done stays 0, a later draw request is still served.
REQ-041 Boot timeout: withhold i_done[0] -> FAULT after 100 cycles, o_ready=0, requests ignored until reset.
REQ-042 Reset during BUSY -> all outputs at reset values, o_start=001 in the first cycle after reset release.
